// File: rtl/ssd_image_pkg.sv
// ssd_image_pkg: shared state type, image RAM geometry and master indices
// for the image RAM arbiter.
package ssd_image_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
   localparam int IMG_DEPTH  = 14848;
   localparam int IMG_ADDR_W = 14;
   localparam int IMG_DATA_W = 32;
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;
   function automatic int hold_w(input int max_hold);
      return $clog2(max_hold + 1);
   endfunction
endpackage

// File: rtl/ssd_rr_grant.sv
// ssd_rr_grant: two-master round-robin grant with bounded burst ownership.
// Grants are combinational; owner, hold count and priority pointer are registered.
module ssd_rr_grant
   import ssd_image_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   localparam int HW = hold_w(MAX_HOLD)
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);
   localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);
   arb_state_t state;
   logic [HW-1:0] hold_cnt;
   logic rr_ptr;
   logic under, keep0, keep1;
   always_comb begin
      under  = hold_cnt < MAX_H;
      keep0  = req0 & (~req1 | under);
      keep1  = req1 & (~req0 | under);
      grant0 = state == OWN0 ? keep0 : state == OWN1 ? ~keep1 & req0 : req0 & (~req1 | rr_ptr == M0);
      grant1 = state == OWN1 ? keep1 : state == OWN0 ? ~keep0 & req1 : req1 & (~req0 | rr_ptr == M1);
   end
   // Every grant is an accept, so ownership advances on the grant itself.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         rr_ptr   <= M0;
      end else if (!(grant0 | grant1)) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else if ((state == OWN0 && grant0) || (state == OWN1 && grant1)) begin
         hold_cnt <= hold_cnt == MAX_H ? hold_cnt : hold_cnt + HW'(1);
      end else begin
         state    <= grant1 ? OWN1 : OWN0;
         hold_cnt <= HW'(1);
         rr_ptr   <= ~grant1;
      end
endmodule

// File: rtl/ssd_image_ram_arbiter.sv
// ssd_image_ram_arbiter: shares one single-port image RAM between the Nios
// data master (m0) and the SSD pixel-fetch engine (m1).
module ssd_image_ram_arbiter
   import ssd_image_pkg::*;
#(
   parameter int ADDR_W   = IMG_ADDR_W,
   parameter int DATA_W   = IMG_DATA_W,
   parameter int DEPTH    = IMG_DEPTH,
   parameter int MAX_HOLD = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic                ram_debugaccess,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic [DATA_W-1:0]   ram_writedata,
   input  logic [DATA_W-1:0]   ram_readdata,
   output logic                oor_err
);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
   logic grant0, grant1, any, wr, rd_acc, in_range;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rd_data;
   logic rd_owner_q, rd_vld_q, rd_oor_q;

   ssd_rr_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
      .clk    (clk),
      .reset  (reset),
      .req0   (m0_read | m0_write),
      .req1   (m1_read | m1_write),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   // A request with both read and write set is handled as a write.
   always_comb begin
      any              = (grant0 | grant1) & ~reset;
      wr               = grant1 ? m1_write : m0_write;
      rd_acc           = any & ~wr & (grant1 ? m1_read : m0_read);
      addr             = any ? (grant1 ? m1_address : m0_address) : '0;
      in_range         = {1'b0, addr} < LIMIT;
      ram_chipselect   = any;
      ram_address      = addr;
      ram_write        = any & wr & in_range;
      ram_debugaccess  = ram_write;
      ram_byteenable   = any ? (grant1 ? m1_byteenable : m0_byteenable) : '0;
      ram_writedata    = any ? (grant1 ? m1_writedata : m0_writedata) : '0;
      m0_waitrequest   = (m0_read | m0_write) & ~grant0;
      m1_waitrequest   = (m1_read | m1_write) & ~grant1;
      m0_readdatavalid = rd_vld_q & (rd_owner_q == M0);
      m1_readdatavalid = rd_vld_q & (rd_owner_q == M1);
      rd_data          = rd_oor_q ? '0 : ram_readdata;
      m0_readdata      = m0_readdatavalid ? rd_data : '0;
      m1_readdata      = m1_readdatavalid ? rd_data : '0;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rd_vld_q   <= 1'b0;
         rd_owner_q <= M0;
         rd_oor_q   <= 1'b0;
         oor_err    <= 1'b0;
      end else begin
         rd_vld_q   <= rd_acc;
         rd_owner_q <= grant1;
         rd_oor_q   <= ~in_range;
         oor_err    <= oor_err | (any & ~in_range);
      end
endmodule

// File: tb/tb_ssd_image_ram_arbiter.sv
// tb_ssd_image_ram_arbiter: directed self-checking bench with a behavioural
// image RAM whose unwritten words read as 0xA0000000 | address.
module tb_ssd_image_ram_arbiter;
   import ssd_image_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [13:0] m0_address = '0, m1_address = '0;
   logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [3:0] m0_byteenable = '0, m1_byteenable = '0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [13:0] ram_address;
   logic ram_chipselect, ram_write, ram_debugaccess;
   logic [3:0] ram_byteenable;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata = '0;
   logic oor_err;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ssd_image_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_debugaccess(ram_debugaccess), .ram_byteenable(ram_byteenable),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata), .oor_err(oor_err)
   );

   logic [31:0] mem [0:16383];
   bit written [0:16383];
   logic [31:0] nxt;
   function automatic logic [31:0] cur(input logic [13:0] a);
      return written[a] ? mem[a] : (32'hA000_0000 | {18'b0, a});
   endfunction
   always @(posedge clk)
      if (ram_chipselect) begin
         if (ram_write && ram_debugaccess) begin
            nxt = cur(ram_address);
            for (int b = 0; b < 4; b++) if (ram_byteenable[b]) nxt[8*b +: 8] = ram_writedata[8*b +: 8];
            mem[ram_address] <= nxt;
            written[ram_address] <= 1'b1;
         end else ram_readdata <= cur(ram_address);
      end

   task automatic idle_all();
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
   endtask

   task automatic reset_dut();
      @(posedge clk); #1;
      idle_all();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_m0_rdv got=%b exp=0", m0_readdatavalid); end
      checks++; if (m1_readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_m1_rdv got=%b exp=0", m1_readdatavalid); end
      checks++; if (m0_readdata !== 32'h0) begin failures++; $display("FAIL rst_m0_rd got=%h exp=0", m0_readdata); end
      checks++; if (m1_readdata !== 32'h0) begin failures++; $display("FAIL rst_m1_rd got=%h exp=0", m1_readdata); end
      checks++; if (oor_err !== 1'b0) begin failures++; $display("FAIL rst_oor got=%b exp=0", oor_err); end
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_m0_wait got=%b exp=0", m0_waitrequest); end
      checks++; if (ram_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs got=%b exp=0", ram_chipselect); end
      checks++; if (dut.u_grant.state !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dut.u_grant.state, IDLE); end
   endtask

   task automatic test_write_read();
      @(posedge clk); #1;
      m0_write = 1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL wr_wait got=%b exp=0", m0_waitrequest); end
      checks++; if (ram_write !== 1'b1) begin failures++; $display("FAIL wr_ram_write got=%b exp=1", ram_write); end
      checks++; if (ram_address !== 14'h0010) begin failures++; $display("FAIL wr_addr got=%h exp=0010", ram_address); end
      @(posedge clk); #1;
      m0_write = 0; m0_read = 1;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL rd_wait got=%b exp=0", m0_waitrequest); end
      @(posedge clk); #1;
      m0_read = 0;
      @(negedge clk);
      checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("FAIL rd_rdv got=%b exp=1", m0_readdatavalid); end
      checks++; if (m0_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", m0_readdata); end
      checks++; if (m1_readdatavalid !== 1'b0) begin failures++; $display("FAIL rd_m1_rdv got=%b exp=0", m1_readdatavalid); end
   endtask

   task automatic test_round_robin();
      logic exp0, prev0;
      reset_dut();
      m0_read = 1; m0_address = 14'h0100; m1_read = 1; m1_address = 14'h0200;
      exp0 = 1'b1; prev0 = 1'b0;
      for (int k = 0; k <= 32; k++) begin
         @(negedge clk);
         if (k < 32) begin
            exp0 = ((k / 8) % 2) == 0;
            checks++; if (m0_waitrequest !== !exp0) begin failures++; $display("FAIL rr_m0_wait k=%0d got=%b exp=%b", k, m0_waitrequest, !exp0); end
            checks++; if (m1_waitrequest !== exp0) begin failures++; $display("FAIL rr_m1_wait k=%0d got=%b exp=%b", k, m1_waitrequest, exp0); end
         end
         if (k > 0) begin
            checks++; if (m0_readdatavalid !== prev0) begin failures++; $display("FAIL rr_m0_rdv k=%0d got=%b exp=%b", k, m0_readdatavalid, prev0); end
            checks++; if (m1_readdatavalid !== !prev0) begin failures++; $display("FAIL rr_m1_rdv k=%0d got=%b exp=%b", k, m1_readdatavalid, !prev0); end
            checks++; if ((prev0 ? m0_readdata : m1_readdata) !== (prev0 ? 32'hA0000100 : 32'hA0000200)) begin
               failures++; $display("FAIL rr_data k=%0d got=%h", k, prev0 ? m0_readdata : m1_readdata);
            end
         end
         prev0 = exp0;
         @(posedge clk); #1;
         if (k == 31) idle_all();
      end
   endtask

   task automatic test_m1_burst();
      int pulses, stalls, waited;
      logic granted;
      pulses = 0; stalls = 0;
      m1_read = 1;
      for (int k = 0; k < 21; k++) begin
         m1_address = 14'(14'h0300 + k);
         if (k == 20) m1_read = 0;
         @(negedge clk);
         if (m1_waitrequest) stalls++;
         if (m1_readdatavalid) begin
            pulses++;
            checks++; if (m1_readdata !== 32'hA0000300 + 32'(k - 1)) begin failures++; $display("FAIL burst_data k=%0d got=%h", k, m1_readdata); end
         end
         @(posedge clk); #1;
      end
      checks++; if (stalls !== 0) begin failures++; $display("FAIL burst_stalls got=%0d exp=0", stalls); end
      checks++; if (pulses !== 20) begin failures++; $display("FAIL burst_pulses got=%0d exp=20", pulses); end
      @(posedge clk); #1;
      m1_read = 1; m1_address = 14'h0300;
      repeat (3) begin @(posedge clk); #1; end
      m0_read = 1; m0_address = 14'h0100;
      waited = 0; granted = 0;
      for (int k = 0; k < 20 && !granted; k++) begin
         @(negedge clk);
         if (m0_waitrequest) waited++; else granted = 1;
         @(posedge clk); #1;
      end
      idle_all();
      checks++; if (granted !== 1'b1) begin failures++; $display("FAIL mid_granted got=%b exp=1", granted); end
      checks++; if (waited !== 5) begin failures++; $display("FAIL mid_wait got=%0d exp=5", waited); end
   endtask

   task automatic test_out_of_range();
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (oor_err !== 1'b0) begin failures++; $display("FAIL oor_pre got=%b exp=0", oor_err); end
      @(posedge clk); #1;
      m0_write = 1; m0_address = 14'd14848; m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL oor_wr_wait got=%b exp=0", m0_waitrequest); end
      checks++; if (ram_write !== 1'b0) begin failures++; $display("FAIL oor_ram_write got=%b exp=0", ram_write); end
      @(posedge clk); #1;
      m0_write = 0; m0_read = 1; m0_address = 14'h3FFF;
      @(negedge clk);
      checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_set got=%b exp=1", oor_err); end
      @(posedge clk); #1;
      m0_read = 0;
      @(negedge clk);
      checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("FAIL oor_rdv got=%b exp=1", m0_readdatavalid); end
      checks++; if (m0_readdata !== 32'h0) begin failures++; $display("FAIL oor_rdata got=%h exp=0", m0_readdata); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_sticky got=%b exp=1", oor_err); end
   endtask

   localparam logic [3:0]  BE_V [5] = '{4'hF, 4'b0100, 4'h0, 4'b0010, 4'h0};
   localparam logic [31:0] WD_V [5] = '{32'h11223344, 32'h00AB0000, 32'h0, 32'h0000CD00, 32'h0};
   localparam logic [31:0] RD_V [5] = '{32'h0, 32'h0, 32'h11AB3344, 32'h0, 32'h11ABCD44};

   task automatic test_byteenable();
      @(posedge clk); #1;
      for (int k = 0; k <= 5; k++) begin
         if (k < 5) begin
            m0_address = 14'h0020; m0_write = BE_V[k] != 0; m0_read = BE_V[k] == 0;
            m0_byteenable = BE_V[k]; m0_writedata = WD_V[k];
         end else idle_all();
         @(negedge clk);
         if (k < 5 && BE_V[k] != 0) begin
            checks++; if (ram_byteenable !== BE_V[k]) begin failures++; $display("FAIL be_pass k=%0d got=%b exp=%b", k, ram_byteenable, BE_V[k]); end
         end
         if (k > 0 && BE_V[k-1] == 0) begin
            checks++; if (m0_readdatavalid !== 1'b1) begin failures++; $display("FAIL be_rdv k=%0d got=%b exp=1", k, m0_readdatavalid); end
            checks++; if (m0_readdata !== RD_V[k-1]) begin failures++; $display("FAIL be_data k=%0d got=%h exp=%h", k, m0_readdata, RD_V[k-1]); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic e0;
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            m0_read = (k % 2) == 0; m1_read = (k % 2) == 1;
            m0_address = 14'(14'h0040 + k); m1_address = 14'(14'h0040 + k);
         end else idle_all();
         @(negedge clk);
         if (k < 4) begin
            checks++; if ((m0_waitrequest | m1_waitrequest) !== 1'b0) begin failures++; $display("FAIL b2b_wait k=%0d got=%b%b exp=00", k, m0_waitrequest, m1_waitrequest); end
         end
         if (k > 0) begin
            e0 = ((k - 1) % 2) == 0;
            checks++; if (m0_readdatavalid !== e0) begin failures++; $display("FAIL b2b_m0_rdv k=%0d got=%b exp=%b", k, m0_readdatavalid, e0); end
            checks++; if (m1_readdatavalid !== !e0) begin failures++; $display("FAIL b2b_m1_rdv k=%0d got=%b exp=%b", k, m1_readdatavalid, !e0); end
            checks++; if ((e0 ? m0_readdata : m1_readdata) !== 32'hA0000040 + 32'(k - 1)) begin
               failures++; $display("FAIL b2b_data k=%0d got=%h", k, e0 ? m0_readdata : m1_readdata);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m0_read = 1; m0_address = 14'h0100;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL rmid_accept got=%b exp=0", m0_waitrequest); end
      @(posedge clk); #1;
      m0_read = 0; reset = 1; m1_read = 1; m1_address = 14'h0200;
      @(negedge clk);
      checks++; if (m0_readdatavalid !== 1'b0) begin failures++; $display("FAIL rmid_rdv got=%b exp=0", m0_readdatavalid); end
      checks++; if (m0_readdata !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h exp=0", m0_readdata); end
      checks++; if (ram_chipselect !== 1'b0) begin failures++; $display("FAIL rmid_cs got=%b exp=0", ram_chipselect); end
      checks++; if (dut.u_grant.state !== IDLE) begin failures++; $display("FAIL rmid_state got=%0d exp=%0d", dut.u_grant.state, IDLE); end
      @(posedge clk); #1;
      reset = 0; m0_read = 1; m1_read = 1;
      @(negedge clk);
      checks++; if (m0_waitrequest !== 1'b0) begin failures++; $display("FAIL rmid_m0_prio got=%b exp=0", m0_waitrequest); end
      checks++; if (m1_waitrequest !== 1'b1) begin failures++; $display("FAIL rmid_m1_wait got=%b exp=1", m1_waitrequest); end
      checks++; if (oor_err !== 1'b0) begin failures++; $display("FAIL rmid_oor got=%b exp=0", oor_err); end
      @(posedge clk); #1;
      idle_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_m1_burst();
      test_out_of_range();
      test_byteenable();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
